// File: rtl/fir_mac_if.sv
// fir_mac_if: sample/coefficient/result bundle for fir_mac; sat exists only with FIR_SATURATE_EN
interface fir_mac_if #(
   parameter int WIDTH     = 8,
   parameter int TAPS      = 4,
   parameter int OUT_WIDTH = 16
);
   logic signed [WIDTH-1:0]     in;
   logic                        in_valid;
   logic                        in_ready;
   logic                        coef_we;
   logic [$clog2(TAPS)-1:0]     coef_addr;
   logic signed [WIDTH-1:0]     coef_in;
   logic signed [OUT_WIDTH-1:0] out;
   logic                        out_valid;
`ifdef FIR_SATURATE_EN
   logic                        sat;
   modport master (output in, in_valid, coef_we, coef_addr, coef_in,
                   input in_ready, out, out_valid, sat);
   modport slave (input in, in_valid, coef_we, coef_addr, coef_in,
                  output in_ready, out, out_valid, sat);
`else
   modport master (output in, in_valid, coef_we, coef_addr, coef_in,
                   input in_ready, out, out_valid);
   modport slave (input in, in_valid, coef_we, coef_addr, coef_in,
                  output in_ready, out, out_valid);
`endif
endinterface

// File: rtl/fir_mac.sv
// fir_mac: serial single-multiplier FIR stage, one result per TAPS+2 cycles; FIR_SATURATE_EN selects clamping output with sat flag
module fir_mac #(
   parameter int WIDTH     = 8,
   parameter int TAPS      = 4,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 0
) (
   input logic       clk,
   input logic       reset,
   fir_mac_if.slave  fir
);
   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = 2 * WIDTH + AW;
   localparam logic [AW-1:0] LAST     = AW'(TAPS - 1);
   localparam logic [AW:0]   TAPS_LIM = (AW + 1)'(TAPS);
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t                      state, state_nxt;
   logic signed [WIDTH-1:0]     x [TAPS];
   logic signed [WIDTH-1:0]     h [TAPS];
   logic signed [ACC_W-1:0]     acc;
   logic signed [2*WIDTH-1:0]   prod;
   logic [AW-1:0]               idx;
   logic                        accept;
   logic                        coef_ok;
   logic signed [OUT_WIDTH-1:0] res;
   assign accept  = fir.in_valid && fir.in_ready;
   assign coef_ok = fir.coef_we && state == IDLE && {1'b0, fir.coef_addr} < TAPS_LIM;
   assign prod    = x[idx] * h[idx];
`ifdef FIR_SATURATE_EN
   localparam int EW = (ACC_W > OUT_WIDTH ? ACC_W : OUT_WIDTH) + 1;
   localparam logic signed [EW-1:0] MAX_V = (EW'(1) <<< (OUT_WIDTH - 1)) - EW'(1);
   localparam logic signed [EW-1:0] MIN_V = ~MAX_V;
   logic signed [EW-1:0] wide;
   logic                 clip_hi, clip_lo;
   assign wide    = EW'(acc >>> SHIFT);
   assign clip_hi = wide > MAX_V;
   assign clip_lo = wide < MIN_V;
   assign res     = clip_hi ? OUT_WIDTH'(MAX_V) : clip_lo ? OUT_WIDTH'(MIN_V) : OUT_WIDTH'(wide);
`else
   assign res = OUT_WIDTH'(acc >>> SHIFT);
`endif
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end
   // next state and ready: only IDLE takes samples, MAC runs until the last tap
   always_comb begin
      state_nxt    = IDLE;
      fir.in_ready = 1'b0;
      case (state)
         IDLE: begin
            fir.in_ready = 1'b1;
            state_nxt    = fir.in_valid ? MAC : IDLE;
         end
         MAC:     state_nxt = idx == LAST ? DONE : MAC;
         default: state_nxt = IDLE;
      endcase
   end
   // delay line, coefficient bank, accumulator and registered result
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
            h[i] <= '0;
         end
         acc           <= '0;
         idx           <= '0;
         fir.out       <= '0;
         fir.out_valid <= 1'b0;
`ifdef FIR_SATURATE_EN
         fir.sat       <= 1'b0;
`endif
      end else begin
         fir.out_valid <= state == DONE;
         if (coef_ok) h[fir.coef_addr] <= fir.coef_in;
         if (accept) begin
            x[0] <= fir.in;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
         end
         if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            idx <= idx + AW'(1);
         end
         if (state == DONE) begin
            fir.out <= res;
`ifdef FIR_SATURATE_EN
            fir.sat <= clip_hi || clip_lo;
`endif
         end
      end
   end
endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: directed bench for fir_mac, a 16-bit-output and an 8-bit-output instance fed identically
module tb_fir_mac;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic signed [7:0] in_s = '0;
   logic signed [7:0] coef_in = '0;
   logic              in_valid = 1'b0;
   logic              coef_we = 1'b0;
   logic [1:0]        coef_addr = '0;
   int                errors = 0;
   int                checks = 0;
   int                got_a, got_b, n;
   logic              seen;
   int                t2_in [4] = '{1, 0, 0, 0};
   int                t2_exp[4] = '{1, 2, 3, 4};
   int                t3_exp[4] = '{10, 30, 60, 100};

   always #5 clk = ~clk;

   fir_mac_if #(.WIDTH(8), .TAPS(4), .OUT_WIDTH(16)) a_if ();
   fir_mac_if #(.WIDTH(8), .TAPS(4), .OUT_WIDTH(8))  b_if ();

   assign a_if.in = in_s;
   assign a_if.in_valid = in_valid;
   assign a_if.coef_we = coef_we;
   assign a_if.coef_addr = coef_addr;
   assign a_if.coef_in = coef_in;
   assign b_if.in = in_s;
   assign b_if.in_valid = in_valid;
   assign b_if.coef_we = coef_we;
   assign b_if.coef_addr = coef_addr;
   assign b_if.coef_in = coef_in;

   fir_mac #(.WIDTH(8), .TAPS(4), .OUT_WIDTH(16), .SHIFT(0)) dut_a (
      .clk(clk), .reset(reset), .fir(a_if.slave));
   fir_mac #(.WIDTH(8), .TAPS(4), .OUT_WIDTH(8), .SHIFT(0)) dut_b (
      .clk(clk), .reset(reset), .fir(b_if.slave));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wcoef(input logic [1:0] a, input logic signed [7:0] v);
      @(negedge clk);
      coef_we = 1'b1;
      coef_addr = a;
      coef_in = v;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic set_h(input logic signed [7:0] h0, h1, h2, h3);
      wcoef(2'd0, h0);
      wcoef(2'd1, h1);
      wcoef(2'd2, h2);
      wcoef(2'd3, h3);
   endtask

   task automatic push(input logic signed [7:0] v, input string tag);
      int k = 0;
      @(negedge clk);
      while (!a_if.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      in_s = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!a_if.out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, int'(a_if.out_valid), 1);
      got_a = int'(a_if.out);
      got_b = int'(b_if.out);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready", int'(a_if.in_ready), 1);
      check("rst_out_valid", int'(a_if.out_valid), 0);
      check("rst_out", int'(a_if.out), 0);

      // zero coefficients: busy for TAPS+1 cycles, result 0
      in_s = 8'sd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!a_if.in_ready && n < 20) begin
         n++;
         seen |= a_if.out_valid;
         @(negedge clk);
      end
      check("t1_busy_cycles", n, 5);
      check("t1_early_valid", int'(seen), 0);
      check("t1_out_valid", int'(a_if.out_valid), 1);
      check("t1_out", int'(a_if.out), 0);
      @(negedge clk);
      check("t1_pulse_end", int'(a_if.out_valid), 0);

      // impulse response
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      set_h(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      for (int i = 0; i < 4; i++) begin
         push(8'(t2_in[i]), $sformatf("t2_%0d", i));
         check($sformatf("t2_out%0d", i), got_a, t2_exp[i]);
      end

      // step of 10
      for (int i = 0; i < 4; i++) begin
         push(8'sd10, $sformatf("t3_%0d", i));
         check($sformatf("t3_out%0d", i), got_a, t3_exp[i]);
      end

      // busy: held sample and coefficient write both ignored
      @(negedge clk);
      in_s = 8'sd1;
      in_valid = 1'b1;
      @(negedge clk);
      in_s = 8'sd99;
      coef_we = 1'b1;
      coef_addr = 2'd3;
      coef_in = 8'sd50;
      check("t6_busy_rdy1", int'(a_if.in_ready), 0);
      @(negedge clk);
      coef_we = 1'b0;
      check("t6_busy_rdy2", int'(a_if.in_ready), 0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!a_if.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_busy_done", int'(a_if.out_valid), 1);
      check("t6_busy_out", int'(a_if.out), 91);
      push(8'sd0, "t6_after");
      check("t6_after_out", got_a, 72);

      // full-scale negative products
      set_h(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
      for (int i = 0; i < 4; i++) push(-8'sd128, $sformatf("t4_%0d", i));
`ifdef FIR_SATURATE_EN
      check("t4_out_a", got_a, 32767);
      check("t4_sat_a", int'(a_if.sat), 1);
      check("t4_out_b", got_b, 127);
`else
      check("t4_out_a", got_a, 0);
      check("t4_out_b", got_b, 0);
`endif

      // full-scale positive products
      set_h(8'sd127, 8'sd127, 8'sd127, 8'sd127);
      for (int i = 0; i < 4; i++) push(8'sd127, $sformatf("t5_%0d", i));
`ifdef FIR_SATURATE_EN
      check("t5_out_b", got_b, 127);
      check("t5_sat_b", int'(b_if.sat), 1);
      check("t5_out_a", got_a, 32767);
`else
      check("t5_out_b", got_b, 4);
      check("t5_out_a", got_a, -1020);
`endif

      // reset mid-MAC aborts the result and clears the delay line
      @(negedge clk);
      in_s = 8'sd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_s = 8'sd77;
      @(negedge clk);
      check("t6_mid_rdy", int'(a_if.in_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      check("t6_rst_rdy", int'(a_if.in_ready), 1);
      check("t6_rst_valid", int'(a_if.out_valid), 0);
      check("t6_rst_out", int'(a_if.out), 0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= a_if.out_valid;
      end
      check("t6_no_pulse", int'(seen), 0);
      set_h(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      push(8'sd1, "t6_clr0");
      check("t6_clr0_out", got_a, 1);
      push(8'sd0, "t6_clr1");
      check("t6_clr1_out", got_a, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
